// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a core and the data-memory controller.
// One access in flight at a time; the requester stalls on busy/ready.
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;
  logic        busy;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  rdata, ready, error, busy
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output rdata, ready, error, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request/ready handshake, configurable wait states,
// byte/halfword/word access with sign/zero extension and error reporting.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dmem_ctrl_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned AddrW = IdxW + 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept, aligned, in_range;
  logic              op_go, op_from_in;
  logic              op_we, op_uns;
  logic [1:0]        op_size;
  logic [AddrW-1:0]  op_addr;
  logic [31:0]       op_wdata;
  logic [IdxW-1:0]   op_idx;
  logic [1:0]        op_off;
  logic [31:0]       word, ld_val, wr_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        be;

  assign accept   = bus_io.req && ((state_q == StIdle) || (state_q == StResp));
  assign in_range = {2'b00, bus_io.addr[31:2]} < DEPTH_WORDS;

  always_comb begin
    case (bus_io.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus_io.addr[0];
      2'b10:   aligned = (bus_io.addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    op_go      = 1'b0;
    op_from_in = 1'b0;
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) begin
          op_go   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (!accept) begin
          state_d = StIdle;
        end else if (!(aligned && in_range)) begin
          // Rejected accesses skip the wait states entirely.
          state_d = StResp;
          err_d   = 1'b1;
        end else if (WAIT_STATES == 0) begin
          op_go      = 1'b1;
          op_from_in = 1'b1;
          state_d    = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
    endcase
  end

  // Zero-wait accesses use the live bus; delayed ones use the captured copy.
  always_comb begin
    op_we    = op_from_in ? bus_io.we                 : we_q;
    op_uns   = op_from_in ? bus_io.unsigned_ld        : uns_q;
    op_size  = op_from_in ? bus_io.size               : size_q;
    op_addr  = op_from_in ? bus_io.addr[AddrW-1:0]    : addr_q;
    op_wdata = op_from_in ? bus_io.wdata              : wdata_q;
  end

  assign op_idx = op_addr[AddrW-1:2];
  assign op_off = op_addr[1:0];
  assign word   = mem_q[op_idx];

  always_comb begin
    ld_byte = word[{op_off, 3'b000} +: 8];
    ld_half = word[{op_off[1], 4'b0000} +: 16];
    case (op_size)
      2'b00:   ld_val = {{24{~op_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{~op_uns & ld_half[15]}}, ld_half};
      default: ld_val = word;
    endcase
  end

  always_comb begin
    case (op_size)
      2'b00: begin
        be      = 4'b0001 << op_off;
        wr_word = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be      = op_off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{op_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = op_wdata;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (op_go && op_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[op_idx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (op_go && !op_we) rdata_q <= ld_val;
      if (accept) begin
        we_q    <= bus_io.we;
        size_q  <= bus_io.size;
        uns_q   <= bus_io.unsigned_ld;
        addr_q  <= bus_io.addr[AddrW-1:0];
        wdata_q <= bus_io.wdata;
      end
    end
  end

  assign bus_io.rdata = rdata_q;
  assign bus_io.ready = (state_q == StResp);
  assign bus_io.error = err_q;
  assign bus_io.busy  = (state_q == StWait);
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (0, 3 and 5 wait states) checked against
// a byte-array memory model with directed and randomized accesses.
module tb_dmem_ctrl;
  localparam int unsigned Depth = 64;
  localparam int NDut = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NDut];
  logic        req_a   [NDut];
  logic        we_a    [NDut];
  logic [1:0]  size_a  [NDut];
  logic        uns_a   [NDut];
  logic [31:0] addr_a  [NDut];
  logic [31:0] wdata_a [NDut];
  logic [31:0] rdata_a [NDut];
  logic        ready_a [NDut];
  logic        error_a [NDut];
  logic        busy_a  [NDut];

  int unsigned ws [NDut] = '{0, 3, 5};

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    dmem_ctrl_if bus ();
    assign bus.req         = req_a[g];
    assign bus.we          = we_a[g];
    assign bus.size        = size_a[g];
    assign bus.unsigned_ld = uns_a[g];
    assign bus.addr        = addr_a[g];
    assign bus.wdata       = wdata_a[g];
    assign rdata_a[g]      = bus.rdata;
    assign ready_a[g]      = bus.ready;
    assign error_a[g]      = bus.error;
    assign busy_a[g]       = bus.busy;

    dmem_ctrl #(
      .DEPTH_WORDS(Depth),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 5)
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n[g]),
      .bus_io(bus)
    );
  end

  logic [7:0]  mb     [NDut][Depth*4];
  logic [31:0] exp_rd [NDut];
  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ok(input logic [1:0] sz, input logic [31:0] a);
    bit al;
    case (sz)
      2'd0:    al = 1'b1;
      2'd1:    al = (a[0] == 1'b0);
      2'd2:    al = (a[1:0] == 2'b00);
      default: al = 1'b0;
    endcase
    return al && ((a / 4) < Depth);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_ld(input int g, input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a);
    int nb;
    int base;
    logic [31:0] v;
    nb   = nbytes(sz);
    base = int'(a);
    v    = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[g][base+i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // b2b: entered on the ready cycle of a held request; keep: leave req high.
  task automatic run(input int g, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input bit b2b,
                     input bit keep, input string tag);
    int lat;
    int bsy;
    int exp_lat;
    bit ok;
    lat = 0;
    bsy = 0;
    ok  = model_ok(sz, a);
    if (!b2b) @(negedge clk);
    req_a[g] = 1'b1; we_a[g] = we; size_a[g] = sz; uns_a[g] = uns;
    addr_a[g] = a; wdata_a[g] = wd;
    do begin
      @(negedge clk);
      lat++;
      if (busy_a[g]) bsy++;
    end while (!ready_a[g] && lat < 40);
    if (!keep) req_a[g] = 1'b0;
    if (ok) begin
      if (we) begin
        for (int i = 0; i < nbytes(sz); i++) mb[g][int'(a)+i] = wd[8*i +: 8];
      end else begin
        exp_rd[g] = model_ld(g, sz, uns, a);
      end
    end
    exp_lat = (ok && ws[g] != 0) ? int'(ws[g]) + 1 : 1;
    chk($sformatf("%s.d%0d.latency", tag, g), lat, exp_lat);
    chk($sformatf("%s.d%0d.busy_cycles", tag, g), bsy, ok ? ws[g] : 0);
    chk($sformatf("%s.d%0d.error", tag, g), {31'd0, error_a[g]}, {31'd0, ~ok});
    chk($sformatf("%s.d%0d.rdata", tag, g), rdata_a[g], exp_rd[g]);
  endtask

  initial begin
    int cnt;
    bit prev_keep;
    bit keep;
    logic [31:0] a;
    logic [31:0] v;

    for (int g = 0; g < NDut; g++) begin
      rst_n[g] = 1'b0; req_a[g] = 1'b0; we_a[g] = 1'b0; size_a[g] = 2'd0;
      uns_a[g] = 1'b0; addr_a[g] = '0; wdata_a[g] = '0; exp_rd[g] = '0;
    end
    #12;
    for (int g = 0; g < NDut; g++) begin
      chk($sformatf("reset.d%0d.ready", g), {31'd0, ready_a[g]}, 32'd0);
      chk($sformatf("reset.d%0d.error", g), {31'd0, error_a[g]}, 32'd0);
      chk($sformatf("reset.d%0d.busy", g), {31'd0, busy_a[g]}, 32'd0);
      chk($sformatf("reset.d%0d.rdata", g), rdata_a[g], 32'd0);
    end
    @(negedge clk);
    for (int g = 0; g < NDut; g++) rst_n[g] = 1'b1;

    // Give every word a known value so later loads have defined expectations.
    for (int g = 0; g < NDut; g++)
      for (int w = 0; w < int'(Depth); w++)
        run(g, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0, "fill");

    // Word and sub-word accesses with zero wait states.
    run(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 1'b0, "w0_st");
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "w0_ld");
    chk("w0_ld_const", rdata_a[0], 32'h1234_5678);
    run(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 1'b0, "sb");
    run(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "sb_lw");
    chk("sb_lw_const", rdata_a[0], 32'h1234_AB78);
    run(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, "lb");
    chk("lb_const", rdata_a[0], 32'hFFFF_FFAB);
    run(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0, "lbu");
    chk("lbu_const", rdata_a[0], 32'h0000_00AB);
    run(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, "lh");
    chk("lh_const", rdata_a[0], 32'h0000_1234);
    v = $urandom;
    run(0, 1'b1, 2'd2, 1'b0, 32'h18, v, 1'b0, 1'b1, "b2b_st");
    run(0, 1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0, "b2b_ld");
    chk("b2b_ld_const", rdata_a[0], v);

    // Three wait states: latency, back-to-back and ignored requests.
    run(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 1'b0, "w3_st");
    run(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, "w3_ld");
    run(1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, "w3_b2b");
    chk("w3_b2b_const", rdata_a[1], 32'h0000_1234);

    @(negedge clk);
    req_a[1] = 1'b1; we_a[1] = 1'b0; size_a[1] = 2'd2; addr_a[1] = 32'h10;
    @(negedge clk);
    req_a[1] = 1'b0;
    chk("pulse.busy", {31'd0, busy_a[1]}, 32'd1);
    we_a[1] = 1'b1; addr_a[1] = 32'h14; wdata_a[1] = 32'hDEAD_BEEF; req_a[1] = 1'b1;
    @(negedge clk);
    req_a[1] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready_a[1]) cnt++;
    end
    chk("pulse.ready_count", cnt, 1);
    exp_rd[1] = model_ld(1, 2'd2, 1'b0, 32'h10);
    chk("pulse.rdata", rdata_a[1], exp_rd[1]);
    run(1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, "pulse_rb");

    // Rejected accesses, then readback of the words they must not touch.
    run(1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, "err_lh");
    run(1, 1'b1, 2'd1, 1'b0, 32'h12 | 32'h1, 32'hFFFF, 1'b0, 1'b0, "err_sh");
    run(1, 1'b1, 2'd2, 1'b0, Depth * 4, 32'hCAFE_F00D, 1'b0, 1'b0, "err_range");
    run(1, 1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555, 1'b0, 1'b0, "err_sz3");
    run(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "err_rb10");
    chk("err_rb10_const", rdata_a[1], 32'h1234_5678);
    run(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "err_rb0");

    // Randomized traffic, including chained back-to-back requests.
    for (int g = 0; g < NDut; g++) begin
      prev_keep = 1'b0;
      for (int n = 0; n < 120; n++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, Depth * 4 - 1));
        keep = (n == 119) ? 1'b0 : 1'($urandom_range(0, 1));
        run(g, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, prev_keep, keep, "rnd");
        prev_keep = keep;
      end
    end

    // Reset in the middle of a delayed store.
    run(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "rst_pre");
    @(negedge clk);
    req_a[2] = 1'b1; we_a[2] = 1'b1; size_a[2] = 2'd2; addr_a[2] = 32'h20;
    wdata_a[2] = $urandom | 32'h1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    req_a[2] = 1'b0;
    #1;
    exp_rd[2] = 32'h0;
    chk("midrst.ready", {31'd0, ready_a[2]}, 32'd0);
    chk("midrst.error", {31'd0, error_a[2]}, 32'd0);
    chk("midrst.busy", {31'd0, busy_a[2]}, 32'd0);
    chk("midrst.rdata", rdata_a[2], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    run(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, "midrst_rb");
    chk("midrst_rb_const", rdata_a[2], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
